// File: rtl/chacha_pkg.sv
// Shared types and constants for the move-pulse transmitter.
//   state_t         : move FSM states
//   N_TILES         : board length; the downstream counters own the wrap
//   MAX_STEPS       : largest step count a single move can request
//   GAP_CYC_DEFAULT : default number of idle cycles between advance pulses
package chacha_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_TILES         = 24;
  localparam int MAX_STEPS       = 7;
  localparam int GAP_CYC_DEFAULT = 4;

endpackage

// File: rtl/gap_timer.sv
// Down-counter that spaces consecutive advance pulses.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over en)
//   load_val   : value loaded on load
//   en         : decrement by one this cycle (saturates at zero)
//   expired    : count currently equals 1, i.e. this is the last gap cycle
module gap_timer #(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [GAP_W-1:0] count_q;
  logic [GAP_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == GAP_W'(1));

endmodule

// File: rtl/move_pulse_gen.sv
// Move-pulse transmitter: turns one move request (player, step count) into
// that many single-cycle advance pulses on p_da[player], spaced by GAP_CYC
// idle cycles, with D held high across the whole pulse train.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : move request (accepted only when idle and not on a done cycle)
//   player_sel : target player, latched on acceptance
//   steps      : pulse count, latched on acceptance (0 completes immediately)
//   abort      : cancel the move in progress, no done strobe
//   p_da       : one-hot advance pulse, bit i drives player i+1
//   D          : move enable to all counters
//   busy       : move in progress
//   done       : single-cycle completion strobe
//   steps_left : pulses not yet issued
//
// All outputs are registered from the current state, so every visible output
// trails the FSM state by one cycle: the FSM sits in PULSE one cycle before
// the corresponding p_da bit appears.
module move_pulse_gen
  import chacha_pkg::*;
#(
  parameter int STEP_W  = 3,
  parameter int GAP_CYC = GAP_CYC_DEFAULT,
  parameter int GAP_W   = 8,
  parameter int NPLAYER = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        player_sel,
  input  logic [STEP_W-1:0] steps,
  input  logic              abort,
  output logic [NPLAYER-1:0] p_da,
  output logic              D,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left
);

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [STEP_W-1:0]   left_q, left_d;
  logic [NPLAYER-1:0]  p_da_q, p_da_d;
  logic                d_q, d_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tmr_load;
  logic [GAP_W-1:0]    tmr_val;
  logic                tmr_en;
  logic                tmr_expired;
  logic                moving;
  logic                pulse_en;

  gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    left_d   = left_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // done_q high means we left DONE on the previous edge; a start in
        // the strobe cycle is deliberately dropped.
        if (start && !done_q) begin
          if (steps != '0) begin
            sel_d   = player_sel;
            left_d  = steps;
            state_d = PULSE;
          end else begin
            state_d = DONE;
          end
        end
      end
      PULSE: begin
        if (abort) begin
          left_d   = '0;
          tmr_load = 1'b1;
          state_d  = IDLE;
        end else begin
          left_d = left_q - STEP_W'(1);
          if (left_q == STEP_W'(1)) begin
            state_d = DONE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = GAP_W'(GAP_CYC);
            state_d  = GAP;
          end
        end
      end
      GAP: begin
        if (abort) begin
          left_d   = '0;
          tmr_load = 1'b1;
          state_d  = IDLE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            state_d = PULSE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next-values: abort suppresses anything the current state would
  // otherwise emit on the following cycle.
  assign moving   = ((state_q == PULSE) || (state_q == GAP)) && !abort;
  assign pulse_en = (state_q == PULSE) && !abort;
  assign d_d      = moving;
  assign busy_d   = moving;
  assign done_d   = (state_q == DONE);

  for (genvar gi = 0; gi < NPLAYER; gi++) begin : g_onehot
    assign p_da_d[gi] = pulse_en && (sel_q == 2'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      left_q  <= '0;
      p_da_q  <= '0;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      left_q  <= left_d;
      p_da_q  <= p_da_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign p_da       = p_da_q;
  assign D          = d_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = left_q;

endmodule

// File: tb/tb_move_pulse_gen.sv
module tb_move_pulse_gen;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] player_sel = 2'd0;
  logic [2:0] steps = 3'd0;
  logic [3:0] p_da;
  logic       D;
  logic       busy;
  logic       done;
  logic [2:0] steps_left;

  int checks = 0;
  int failures = 0;

  // Reference move description: cycle 0 is the cycle right after the
  // accepting edge; abort (if nonzero) is the cycle in which abort is high.
  int m_sel = 0;
  int m_steps = 0;
  int m_abort = 0;

  always #5 clk = ~clk;

  move_pulse_gen #(
    .STEP_W  (3),
    .GAP_CYC (G),
    .GAP_W   (8),
    .NPLAYER (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .player_sel (player_sel),
    .steps      (steps),
    .abort      (abort),
    .p_da       (p_da),
    .D          (D),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  // ---------------- reference model (timing formulas) ----------------
  function automatic int last_cyc();
    return (m_steps == 0) ? 0 : 1 + (m_steps - 1) * (G + 1);
  endfunction

  function automatic logic [3:0] exp_pda(int c);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 0; k < m_steps; k++)
      if (c == 1 + k * (G + 1) && (m_abort == 0 || c <= m_abort))
        r = 4'(1 << m_sel);
    return r;
  endfunction

  function automatic logic exp_d(int c);
    return (m_steps > 0) && (c >= 1) && (c <= last_cyc()) &&
           (m_abort == 0 || c <= m_abort);
  endfunction

  function automatic logic exp_done(int c);
    return (m_abort == 0) && (c == last_cyc() + 1);
  endfunction

  function automatic logic [2:0] exp_left(int c);
    int n;
    n = 0;
    if (m_abort != 0 && c > m_abort) return 3'd0;
    for (int k = 0; k < m_steps; k++)
      if (1 + k * (G + 1) <= c) n++;
    return 3'(m_steps - n);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic start_move(input int sel, input int st);
    player_sel = 2'(sel);
    steps = 3'(st);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_sel = sel;
    m_steps = st;
    m_abort = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    checks++; if (p_da !== 4'd0) begin failures++; $display("FAIL reset_pda got=%b exp=0000", p_da); end
    checks++; if (D !== 1'b0) begin failures++; $display("FAIL reset_D got=%b exp=0", D); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (steps_left !== 3'd0) begin failures++; $display("FAIL reset_left got=%0d exp=0", steps_left); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    start_move(1, 3);
    for (int c = 1; c <= 14; c++) begin
      next_cyc();
      @(negedge clk);
      checks++; if (p_da !== exp_pda(c)) begin failures++; $display("FAIL basic_pda c=%0d got=%b exp=%b", c, p_da, exp_pda(c)); end
      checks++; if (D !== exp_d(c)) begin failures++; $display("FAIL basic_D c=%0d got=%b exp=%b", c, D, exp_d(c)); end
      checks++; if (busy !== exp_d(c)) begin failures++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy, exp_d(c)); end
      checks++; if (done !== exp_done(c)) begin failures++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, done, exp_done(c)); end
      checks++; if (steps_left !== exp_left(c)) begin failures++; $display("FAIL basic_left c=%0d got=%0d exp=%0d", c, steps_left, exp_left(c)); end
    end
    $display("test_basic sel=1 steps=3 done");
  endtask

  task automatic test_zero_steps();
    start_move(2, 0);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy c=0 got=%b exp=0", busy); end
    for (int c = 1; c <= 4; c++) begin
      next_cyc();
      @(negedge clk);
      checks++; if (p_da !== 4'd0) begin failures++; $display("FAIL zero_pda c=%0d got=%b exp=0000", c, p_da); end
      checks++; if (D !== 1'b0) begin failures++; $display("FAIL zero_D c=%0d got=%b exp=0", c, D); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy c=%0d got=%b exp=0", c, busy); end
      checks++; if (done !== exp_done(c)) begin failures++; $display("FAIL zero_done c=%0d got=%b exp=%b", c, done, exp_done(c)); end
    end
    $display("test_zero_steps done");
  endtask

  task automatic test_ignore_start();
    start_move(3, 2);
    for (int c = 1; c <= 9; c++) begin
      next_cyc();
      if (c == 3) begin
        start = 1'b1;
        player_sel = 2'd0;
        steps = 3'd5;
      end
      @(negedge clk);
      checks++; if (p_da !== exp_pda(c)) begin failures++; $display("FAIL ignore_pda c=%0d got=%b exp=%b", c, p_da, exp_pda(c)); end
      checks++; if (done !== exp_done(c)) begin failures++; $display("FAIL ignore_done c=%0d got=%b exp=%b", c, done, exp_done(c)); end
    end
    $display("test_ignore_start done");
  endtask

  task automatic test_abort();
    start_move(0, 7);
    m_abort = 7;
    for (int c = 1; c <= 14; c++) begin
      next_cyc();
      if (c == 7) abort = 1'b1;
      @(negedge clk);
      checks++; if (p_da !== exp_pda(c)) begin failures++; $display("FAIL abort_pda c=%0d got=%b exp=%b", c, p_da, exp_pda(c)); end
      checks++; if (D !== exp_d(c)) begin failures++; $display("FAIL abort_D c=%0d got=%b exp=%b", c, D, exp_d(c)); end
      checks++; if (done !== exp_done(c)) begin failures++; $display("FAIL abort_done c=%0d got=%b exp=%b", c, done, exp_done(c)); end
      checks++; if (steps_left !== exp_left(c)) begin failures++; $display("FAIL abort_left c=%0d got=%0d exp=%0d", c, steps_left, exp_left(c)); end
    end
    $display("test_abort steps=7 abort@7 done");
  endtask

  task automatic test_async_reset();
    start_move(1, 5);
    for (int c = 1; c <= 3; c++) next_cyc();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (p_da !== 4'd0) begin failures++; $display("FAIL areset_pda got=%b exp=0000", p_da); end
    checks++; if (D !== 1'b0) begin failures++; $display("FAIL areset_D got=%b exp=0", D); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL areset_done got=%b exp=0", done); end
    checks++; if (steps_left !== 3'd0) begin failures++; $display("FAIL areset_left got=%0d exp=0", steps_left); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (p_da !== 4'd0 || D !== 1'b0) begin failures++; $display("FAIL areset_idle got p_da=%b D=%b exp=0000/0", p_da, D); end
    end
    start_move(3, 1);
    for (int c = 1; c <= 4; c++) begin
      next_cyc();
      @(negedge clk);
      checks++; if (p_da !== exp_pda(c)) begin failures++; $display("FAIL areset_pda c=%0d got=%b exp=%b", c, p_da, exp_pda(c)); end
      checks++; if (D !== exp_d(c)) begin failures++; $display("FAIL areset_D c=%0d got=%b exp=%b", c, D, exp_d(c)); end
      checks++; if (done !== exp_done(c)) begin failures++; $display("FAIL areset_done c=%0d got=%b exp=%b", c, done, exp_done(c)); end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_done_start();
    start_move(0, 1);
    for (int c = 1; c <= 3; c++) begin
      next_cyc();
      if (c == 2 || c == 3) begin
        start = 1'b1;
        player_sel = 2'd2;
        steps = 3'd2;
      end
      @(negedge clk);
      checks++; if (done !== exp_done(c)) begin failures++; $display("FAIL dstart_done c=%0d got=%b exp=%b", c, done, exp_done(c)); end
    end
    // Cycle after the second request: that request's own cycle 0.
    next_cyc();
    m_sel = 2; m_steps = 2; m_abort = 0;
    @(negedge clk);
    checks++; if (p_da !== 4'd0) begin failures++; $display("FAIL dstart_early_pda got=%b exp=0000", p_da); end
    for (int c = 1; c <= 12; c++) begin
      next_cyc();
      @(negedge clk);
      checks++; if (p_da !== exp_pda(c)) begin failures++; $display("FAIL dstart_pda c=%0d got=%b exp=%b", c, p_da, exp_pda(c)); end
      checks++; if (D !== exp_d(c)) begin failures++; $display("FAIL dstart_D c=%0d got=%b exp=%b", c, D, exp_d(c)); end
      checks++; if (done !== exp_done(c)) begin failures++; $display("FAIL dstart_done2 c=%0d got=%b exp=%b", c, done, exp_done(c)); end
    end
    $display("test_done_start done");
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int sel, st, lastc, lim;
      sel = int'($urandom_range(0, 3));
      st = int'($urandom_range(0, 7));
      start_move(sel, st);
      lastc = last_cyc();
      if (lastc >= 2 && $urandom_range(0, 2) == 0)
        m_abort = int'($urandom_range(1, lastc - 1));
      lim = (m_abort != 0) ? m_abort : lastc + 1;
      for (int c = 1; c <= lastc + 2; c++) begin
        next_cyc();
        if (c <= lim && $urandom_range(0, 3) == 0) begin
          start = 1'b1;
          player_sel = 2'($urandom_range(0, 3));
          steps = 3'($urandom_range(0, 7));
        end
        if (c == m_abort) abort = 1'b1;
        if (m_abort == 0 && c >= lastc && c <= lastc + 1) abort = 1'($urandom_range(0, 1));
        @(negedge clk);
        checks++; if (p_da !== exp_pda(c)) begin failures++; $display("FAIL rnd_pda it=%0d c=%0d got=%b exp=%b", it, c, p_da, exp_pda(c)); end
        checks++; if (D !== exp_d(c)) begin failures++; $display("FAIL rnd_D it=%0d c=%0d got=%b exp=%b", it, c, D, exp_d(c)); end
        checks++; if (busy !== exp_d(c)) begin failures++; $display("FAIL rnd_busy it=%0d c=%0d got=%b exp=%b", it, c, busy, exp_d(c)); end
        checks++; if (done !== exp_done(c)) begin failures++; $display("FAIL rnd_done it=%0d c=%0d got=%b exp=%b", it, c, done, exp_done(c)); end
        checks++; if (steps_left !== exp_left(c)) begin failures++; $display("FAIL rnd_left it=%0d c=%0d got=%0d exp=%0d", it, c, steps_left, exp_left(c)); end
      end
      $display("move it=%0d sel=%0d steps=%0d abort=%0d", it, sel, st, m_abort);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_steps();
    test_ignore_start();
    test_abort();
    test_async_reset();
    test_done_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
